// File: rtl/vec_ctrl_sequencer.sv
// Vector datapath sequencer: accepts one instruction at a time, decodes it into the
// datapath control bundle, holds the bundle through execution and retires on completion or watchdog.
//   state  | meaning
//   IDLE   | ready for an instruction, controls low
//   DECODE | classify inst_q, load control bundle or flag illegal
//   EXEC   | controls held, waiting for completion or watchdog expiry
//   RETIRE | exec_done pulse, then back to IDLE
`ifndef XLEN
`define XLEN 32
`endif

module vec_ctrl_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              inst_valid,
  input  logic [`XLEN-1:0]  instruction,
  output logic              inst_ready,
  input  logic              inst_done,
  input  logic              st_done,
  output logic              busy,
  output logic              exec_done,
  output logic              illegal_inst,
  output logic              timeout_err,
  output logic              vl_sel,
  output logic              vtype_sel,
  output logic              lumop_sel,
  output logic              rs1rd_de,
  output logic              rs1_sel,
  output logic              csrwr_en,
  output logic              vec_reg_wr_en,
  output logic              mask_operation,
  output logic              mask_wr_en,
  output logic [1:0]        data_mux1_sel,
  output logic              data_mux2_sel,
  output logic              stride_sel,
  output logic              ld_inst
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RETIRE} state_t;

  typedef struct packed {
    logic       vl_sel;
    logic       vtype_sel;
    logic       lumop_sel;
    logic       rs1rd_de;
    logic       rs1_sel;
    logic       csrwr_en;
    logic       vec_reg_wr_en;
    logic       mask_operation;
    logic       mask_wr_en;
    logic [1:0] data_mux1_sel;
    logic       data_mux2_sel;
    logic       stride_sel;
    logic       ld_inst;
  } ctrl_t;

  localparam logic [6:0]       OP_V     = 7'b1010111;
  localparam logic [6:0]       OP_LD    = 7'b0000111;
  localparam logic [6:0]       OP_ST    = 7'b0100111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d, dec_ctrl;
  logic [`XLEN-1:0]  inst_q, inst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic              exec_done_d, illegal_d, timeout_d;
  logic              dec_legal, dec_store, cmpl_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_rs2;

  assign opcode     = inst_q[6:0];
  assign funct3     = inst_q[14:12];
  assign unused_rs2 = ^inst_q[24:20];

  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b0;
    dec_store = 1'b0;
    if (opcode == OP_V) begin
      case (funct3)
        3'b111: begin
          if (!inst_q[31] || inst_q[31:30] == 2'b11 || inst_q[31:25] == 7'b1000000) begin
            dec_legal          = 1'b1;
            dec_ctrl.vl_sel    = (inst_q[31:30] == 2'b11);
            dec_ctrl.vtype_sel = (inst_q[31:25] == 7'b1000000);
            dec_ctrl.rs1rd_de  = (inst_q[19:15] == 5'd0) && (inst_q[11:7] != 5'd0);
            dec_ctrl.csrwr_en  = 1'b1;
          end
        end
        3'b000, 3'b100, 3'b011: begin
          dec_legal               = 1'b1;
          dec_ctrl.vec_reg_wr_en  = 1'b1;
          dec_ctrl.mask_operation = ~inst_q[25];
          dec_ctrl.mask_wr_en     = ~inst_q[25];
          if (funct3 == 3'b100)      dec_ctrl.data_mux1_sel = 2'b01;
          else if (funct3 == 3'b011) dec_ctrl.data_mux1_sel = 2'b10;
        end
        default: ;
      endcase
    end else if (opcode == OP_LD || opcode == OP_ST) begin
      dec_legal              = 1'b1;
      dec_store              = (opcode == OP_ST);
      dec_ctrl.rs1_sel       = 1'b1;
      dec_ctrl.data_mux1_sel = 2'b01;
      dec_ctrl.ld_inst       = ~dec_store;
      dec_ctrl.vec_reg_wr_en = ~dec_store;
      // mop 01/11 (indexed) keeps both stride_sel and data_mux2_sel low
      case (inst_q[27:26])
        2'b00: begin
          dec_ctrl.stride_sel = 1'b1;
          dec_ctrl.lumop_sel  = 1'b1;
        end
        2'b10:   dec_ctrl.data_mux2_sel = 1'b1;
        default: ;
      endcase
    end
  end

  assign cmpl_hit = store_q ? st_done : inst_done;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    inst_d      = inst_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    exec_done_d = 1'b0;
    illegal_d   = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ctrl_d = '0;
        if (inst_valid) begin
          inst_d  = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          ctrl_d  = dec_ctrl;
          store_d = dec_store;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
        ctrl_d.csrwr_en = 1'b0;
        cnt_d           = cnt_q + CNT_W'(1);
        // completion is checked first so it wins over a simultaneous expiry
        if (cmpl_hit) begin
          ctrl_d      = '0;
          exec_done_d = 1'b1;
          state_d     = S_RETIRE;
        end else if (cnt_q == CNT_LAST) begin
          ctrl_d    = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      ctrl_q       <= '0;
      inst_q       <= '0;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      exec_done    <= 1'b0;
      illegal_inst <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      inst_q       <= inst_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      exec_done    <= exec_done_d;
      illegal_inst <= illegal_d;
      timeout_err  <= timeout_d;
    end
  end

  assign inst_ready     = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign vl_sel         = ctrl_q.vl_sel;
  assign vtype_sel      = ctrl_q.vtype_sel;
  assign lumop_sel      = ctrl_q.lumop_sel;
  assign rs1rd_de       = ctrl_q.rs1rd_de;
  assign rs1_sel        = ctrl_q.rs1_sel;
  assign csrwr_en       = ctrl_q.csrwr_en;
  assign vec_reg_wr_en  = ctrl_q.vec_reg_wr_en;
  assign mask_operation = ctrl_q.mask_operation;
  assign mask_wr_en     = ctrl_q.mask_wr_en;
  assign data_mux1_sel  = ctrl_q.data_mux1_sel;
  assign data_mux2_sel  = ctrl_q.data_mux2_sel;
  assign stride_sel     = ctrl_q.stride_sel;
  assign ld_inst        = ctrl_q.ld_inst;

endmodule

// File: tb/tb_vec_ctrl_sequencer.sv
// Bench for vec_ctrl_sequencer: directed scenarios plus randomized instructions checked
// against a transaction-level decode/timing model; short watchdog (8 cycles) to reach expiry.
`ifndef XLEN
`define XLEN 32
`endif

module tb_vec_ctrl_sequencer;
  localparam int TO = 8;
  localparam logic [13:0] CSR_BIT = 14'h100;

  logic        clk = 1'b0;
  logic        n_rst, inst_valid, inst_done, st_done;
  logic [31:0] instruction;
  logic        inst_ready, busy, exec_done, illegal_inst, timeout_err;
  logic        vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csrwr_en;
  logic        vec_reg_wr_en, mask_operation, mask_wr_en, data_mux2_sel, stride_sel, ld_inst;
  logic [1:0]  data_mux1_sel;
  logic [13:0] ctrl_vec;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  vec_ctrl_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .inst_valid(inst_valid), .instruction(instruction),
    .inst_ready(inst_ready), .inst_done(inst_done), .st_done(st_done), .busy(busy),
    .exec_done(exec_done), .illegal_inst(illegal_inst), .timeout_err(timeout_err),
    .vl_sel(vl_sel), .vtype_sel(vtype_sel), .lumop_sel(lumop_sel), .rs1rd_de(rs1rd_de),
    .rs1_sel(rs1_sel), .csrwr_en(csrwr_en), .vec_reg_wr_en(vec_reg_wr_en),
    .mask_operation(mask_operation), .mask_wr_en(mask_wr_en), .data_mux1_sel(data_mux1_sel),
    .data_mux2_sel(data_mux2_sel), .stride_sel(stride_sel), .ld_inst(ld_inst)
  );

  assign ctrl_vec = {vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csrwr_en, vec_reg_wr_en,
                     mask_operation, mask_wr_en, data_mux1_sel, data_mux2_sel, stride_sel, ld_inst};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Decode model: class from opcode/funct3, control bundle from the class rules.
  function automatic void model(input logic [31:0] w, output bit legal, output bit is_st,
                                output logic [13:0] ctrl);
    logic [6:0] opc;
    logic [2:0] f3;
    logic vl, vt, lu, rr, r1, cw, wr, mo, mw, m2, ss, ld;
    logic [1:0] m1;
    bit ivli, vlr;
    opc = w[6:0];
    f3  = w[14:12];
    {vl, vt, lu, rr, r1, cw, wr, mo, mw, m2, ss, ld} = '0;
    m1 = 2'b00;
    legal = 0;
    is_st = 0;
    if (opc == 7'b1010111 && f3 == 3'b111) begin
      ivli  = (w[31:30] == 2'b11);
      vlr   = (w[31:25] == 7'b1000000);
      legal = !w[31] || ivli || vlr;
      if (legal) begin
        vl = ivli;
        vt = vlr;
        rr = (w[19:15] == 5'd0) && (w[11:7] != 5'd0);
        cw = 1'b1;
      end
    end else if (opc == 7'b1010111 && (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011)) begin
      legal = 1;
      wr = 1'b1;
      m1 = (f3 == 3'b100) ? 2'b01 : (f3 == 3'b011) ? 2'b10 : 2'b00;
      mo = !w[25];
      mw = !w[25];
    end else if (opc == 7'b0000111 || opc == 7'b0100111) begin
      legal = 1;
      is_st = (opc == 7'b0100111);
      r1 = 1'b1;
      m1 = 2'b01;
      ld = !is_st;
      wr = !is_st;
      ss = (w[27:26] == 2'b00);
      lu = ss;
      m2 = (w[27:26] == 2'b10);
    end
    ctrl = {vl, vt, lu, rr, r1, cw, wr, mo, mw, m1, m2, ss, ld};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [2:0]  f3_arith [3];
    logic [2:0]  f3_bad [4];
    f3_arith = '{3'b000, 3'b100, 3'b011};
    f3_bad   = '{3'b001, 3'b010, 3'b101, 3'b110};
    w = $urandom;
    case ($urandom_range(0, 5))
      0: begin
        w[6:0] = 7'b1010111;
        w[14:12] = 3'b111;
        if ($urandom_range(0, 1) == 1) w[19:15] = 5'd0;
        case ($urandom_range(0, 3))
          0: w[31] = 1'b0;
          1: w[31:30] = 2'b11;
          2: w[31:25] = 7'b1000000;
          default: begin
            w[31:30] = 2'b10;
            if (w[29:25] == 5'd0) w[25] = 1'b1;
          end
        endcase
      end
      1: begin w[6:0] = 7'b1010111; w[14:12] = f3_arith[$urandom_range(0, 2)]; end
      2: begin w[6:0] = 7'b1010111; w[14:12] = f3_bad[$urandom_range(0, 3)]; end
      3: w[6:0] = 7'b0000111;
      4: w[6:0] = 7'b0100111;
      default: begin
        if (w[6:0] == 7'b1010111 || w[6:0] == 7'b0000111 || w[6:0] == 7'b0100111)
          w[4] = ~w[4];
      end
    endcase
    return w;
  endfunction

  // noise: 0 none, 1 random, 2 always on the completion input that must be ignored
  task automatic run_inst(input logic [31:0] ins, input int done_at, input bit hold_valid,
                          input int noise);
    bit legal, is_st;
    logic [13:0] exp;
    int last;
    logic nz;
    model(ins, legal, is_st, exp);
    @(negedge clk);
    inst_valid  = 1'b1;
    instruction = ins;
    chk("idle_ready", 32'(inst_ready), 1);
    chk("idle_ctrl", 32'(ctrl_vec), 0);
    @(negedge clk);
    if (hold_valid) instruction = ins ^ 32'h0000_0f80;
    else inst_valid = 1'b0;
    chk("dec_busy", 32'({busy, inst_ready}), 32'b10);
    chk("dec_ctrl", 32'(ctrl_vec), 0);
    if (!legal) begin
      @(negedge clk);
      inst_valid = 1'b0;
      chk("ill_pulse", 32'({illegal_inst, inst_ready, exec_done, timeout_err}), 32'b1100);
      chk("ill_ctrl", 32'(ctrl_vec), 0);
      @(negedge clk);
      chk("ill_clear", 32'({illegal_inst, inst_ready}), 32'b01);
      return;
    end
    last = (done_at < TO) ? done_at : TO;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      nz = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      inst_done = is_st ? nz : (i == done_at);
      st_done   = is_st ? (i == done_at) : nz;
      chk("exec_ctrl", 32'(ctrl_vec), 32'((i == 1) ? exp : (exp & ~CSR_BIT)));
      chk("exec_flags", 32'({busy, inst_ready, exec_done, timeout_err, illegal_inst}), 32'b10000);
    end
    @(negedge clk);
    inst_done = 1'b0;
    st_done   = 1'b0;
    if (hold_valid) inst_valid = 1'b0;
    if (done_at <= TO) begin
      chk("retire_flags", 32'({exec_done, busy, timeout_err, illegal_inst}), 32'b1100);
      chk("retire_ctrl", 32'(ctrl_vec), 0);
      @(negedge clk);
      chk("post_retire", 32'({inst_ready, exec_done}), 32'b10);
    end else begin
      chk("wd_flags", 32'({timeout_err, inst_ready, exec_done, illegal_inst}), 32'b1100);
      chk("wd_ctrl", 32'(ctrl_vec), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    inst_valid = 1'b1;
    instruction = 32'h0041B157;
    inst_done = 1'b0;
    st_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'({inst_ready, busy, exec_done, illegal_inst, timeout_err}), 32'b10000);
    chk("rst_ctrl", 32'(ctrl_vec), 0);
    n_rst = 1'b1;
    inst_valid = 1'b0;
    @(negedge clk);
    chk("rst_noaccept", 32'({inst_ready, busy}), 32'b10);

    run_inst(32'h010072D7, 3, 1'b0, 0);   // vsetvli x5,x0,e32
    run_inst(32'h0AB56087, 4, 1'b0, 1);   // vlse32 strided load
    run_inst(32'h0AB560A7, 5, 1'b0, 2);   // vsse32: inst_done held high, only st_done retires
    run_inst(32'h0041B157, 2, 1'b1, 1);   // vadd.vi vm=0 with a second valid during EXEC
    run_inst(32'h003100B3, 1, 1'b0, 0);   // opcode 0110011 is illegal
    run_inst(32'h02208157, 1, 1'b0, 0);   // minimum latency
    run_inst(32'h02208157, 100, 1'b0, 1); // watchdog expiry
    run_inst(32'h0AB560A7, TO, 1'b0, 1);  // completion coincides with expiry

    // reset in EXEC aborts silently
    @(negedge clk);
    inst_valid = 1'b1;
    instruction = 32'h0041B157;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    inst_done = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    inst_done = 1'b0;
    chk("rst_exec_state", 32'({inst_ready, exec_done, timeout_err, illegal_inst}), 32'b1000);
    chk("rst_exec_ctrl", 32'(ctrl_vec), 0);
    @(negedge clk);
    chk("rst_exec_after", 32'({inst_ready, exec_done, timeout_err, illegal_inst}), 32'b1000);
    run_inst(32'h0AB56087, 2, 1'b0, 0);

    for (int k = 0; k < 40; k++)
      run_inst(rand_inst(), $urandom_range(1, TO + 2), 1'($urandom_range(0, 1)), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_ctrl_sequencer.md
# vec_ctrl_sequencer

Sequencer for the vector processor datapath: accepts one instruction at a time from the scalar processor over a valid/ready handshake, classifies it (CSR config, unit/strided/indexed load, store, integer vector op), drives every datapath control input for the duration of execution, and retires on the datapath's completion signal or a watchdog timeout. It sits between the scalar-processor interface and the vector datapath and owns the datapath's control-signal bundle.

## Interface
- TIMEOUT_CYCLES, 1024: cycles in EXEC without completion before the watchdog abort.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width.
- clk  in  1  sole clock; all state changes on the rising edge.
- n_rst  in  1  reset, synchronous and active-low.
- inst_valid  in  1  scalar processor offers `instruction`; held stable until accepted.
- instruction  in  `XLEN  the instruction word.
- inst_ready  out  1  high only in IDLE.
- inst_done  in  1  datapath completion (regfile write or CSR update).
- st_done  in  1  store completion from the LSU/memory side.
- busy  out  1  high in every state except IDLE.
- exec_done  out  1  one-cycle pulse on successful retire.
- illegal_inst  out  1  one-cycle pulse on an unsupported encoding.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel  out  1 each  decode selects.
- csrwr_en  out  1  CSR write enable.
- vec_reg_wr_en, mask_operation, mask_wr_en  out  1 each  regfile controls.
- data_mux1_sel  out  2  00 vector, 01 scalar1, 10 immediate.
- data_mux2_sel  out  1  0 vector, 1 scalar2.
- stride_sel, ld_inst  out  1 each  LSU controls.

## Operation
- States: IDLE, DECODE, EXEC, RETIRE.
- IDLE: inst_ready=1. When inst_valid=1, latch instruction into inst_q and go to DECODE. inst_valid in any other state is ignored.
- DECODE is 1 cycle. It classifies inst_q as follows:
  - opcode 1010111 with funct3 111 is CFG: vsetvli when bit31=0, vsetivli when [31:30]=11, vsetvl when [31:25]=1000000.
  - opcode 1010111 with funct3 000, 100 or 011 is ARITH (OPIVV, OPIVX, OPIVI).
  - opcode 0000111 is LOAD. Opcode 0100111 is STORE.
  - Anything else is illegal: pulse illegal_inst and return to IDLE.
  - Legal classes go to EXEC, with control outputs registered on this edge.
- Control values are held for the whole of EXEC and are 0 elsewhere.
  - CFG: vl_sel=1 only for vsetivli. vtype_sel=1 only for vsetvl. rs1rd_de=1 when rs1 field==0 and rd field!=0. csrwr_en=1 for the first EXEC cycle only.
  - LOAD/STORE: rs1_sel=1, data_mux1_sel=01, ld_inst=1 for LOAD only.
    - Unit stride, mop[27:26]=00: stride_sel=1, lumop_sel=1, data_mux2_sel=0.
    - Strided, mop=10: stride_sel=0, data_mux2_sel=1.
    - Indexed, mop=01/11: stride_sel=0, data_mux2_sel=0.
    - LOAD also sets vec_reg_wr_en=1.
  - ARITH: vec_reg_wr_en=1, data_mux2_sel=0. data_mux1_sel is 00 for OPIVV, 01 for OPIVX, 10 for OPIVI. mask_operation=mask_wr_en=0 when vm (bit25)=1, and 1 when vm=0.
- EXEC completion is inst_done (CFG, LOAD, ARITH) or st_done (STORE). The non-matching completion input is ignored.
  - On completion: go to RETIRE.
  - On completion and watchdog expiry in the same cycle: completion wins.
- Watchdog: counter clears on entry to EXEC and increments each EXEC cycle. When it reaches TIMEOUT_CYCLES-1 with no completion, pulse timeout_err, drop all controls and return to IDLE.
- RETIRE lasts 1 cycle: exec_done=1, then IDLE.
- Reset mid-operation aborts with no done/error pulse; inst_q and the counter are cleared.

## Timing
- After the first rising edge with n_rst=0:
  - state IDLE, inst_ready=1.
  - busy, exec_done, illegal_inst, timeout_err and all control outputs are 0.
  - inst_q and the counter are 0.
- Acceptance edge is T. DECODE is T+1, and controls are valid from T+2, the first EXEC cycle.
- Completion sampled at edge E gives RETIRE in cycle E+1 (exec_done high) and IDLE at E+2. The minimum accept-to-accept interval is 4 cycles.
- Illegal: illegal_inst is high in the cycle after DECODE, coincident with IDLE and inst_ready=1.
- csrwr_en is exactly one cycle wide, even if inst_done arrives later.
- Outputs are registered except inst_ready and busy, which are decoded from state.

## Test plan
- Reset: hold n_rst=0 for 2 cycles during inst_valid=1 -> inst_ready=1, all controls 0, no accept.
- vsetvli x5,x0,e32 (rs1=0, rd=5) accepted -> at T+2: csrwr_en=1 for one cycle, rs1rd_de=1, vl_sel=0, vtype_sel=0. inst_done at T+4 -> exec_done at T+5, inst_ready=1 at T+6.
- Strided load vlse32 (mop=10) -> ld_inst=1, stride_sel=0, data_mux1_sel=01, data_mux2_sel=1, vec_reg_wr_en=1 held until inst_done. Repeat with a store: inst_done ignored, retire only on st_done.
- OPIVI vadd.vi with vm=0 -> data_mux1_sel=10, mask_operation=mask_wr_en=1. Second inst_valid during EXEC is not accepted until after RETIRE.
- Opcode 0110011 -> illegal_inst pulse at T+2, no control asserted, next instruction accepted.
- TIMEOUT_CYCLES=8, no completion -> timeout_err at the 8th EXEC cycle. Completion and expiry in the same cycle -> exec_done only. Reset in EXEC -> IDLE, no pulses.
